sim_mem_seq: RTL and testbench

Request sequencer that sits directly upstream of the simulation memory model and is its only driver. It accepts single-word reads, four-word quad reads and byte-lane-masked single-word writes over a valid/ready request channel. It converts each request into the memory's address/oe/wea/din strobes and returns read data or a write acknowledge over a valid/ready response channel. Quad reads wrap within the aligned four-word block, in the KL10 memory style.

---
 rtl/sim_mem_seq.sv | 131 +++++++++++++
 tb/tb_sim_mem_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_seq.sv
// Request sequencer driving the simulation memory: single reads, wrapping quad reads, byte-masked writes.
// Two cycles per beat (strobe cycle, then response hold); stalls in RSP with no memory activity while rsp_ready=0.
module sim_mem_seq #(
  parameter int SIZE   = 4096,
  parameter int WIDTH  = 36,
  parameter int NBYTES = 4,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_quad,
  input  logic [AW-1:0]     req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic [NBYTES-1:0] req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_last,
  output logic [AW-1:0]     mem_addr,
  output logic [WIDTH-1:0]  mem_din,
  output logic [NBYTES-1:0] mem_wea,
  output logic              mem_oe,
  input  logic [WIDTH-1:0]  mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RSP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_live;
  logic               r_quad;
  logic [AW-1:0]      r_addr;
  logic [AW-1:0]      r_addr_hold;
  logic [WIDTH-1:0]   r_wdata;
  logic [NBYTES-1:0]  r_be;
  logic [1:0]         r_beat;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_rsp_last;
  logic [1:0]         w_lo;
  logic [AW-1:0]      w_rd_addr;
  logic               w_accept;

  // Quad beats wrap inside the aligned four-word block.
  assign w_lo      = r_addr[1:0] + r_beat;
  assign w_rd_addr = {r_addr[AW-1:2], w_lo};
  assign w_accept  = (r_state == S_IDLE) && r_live && req_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_oe    = 1'b0;
    mem_wea   = '0;
    mem_din   = '0;
    mem_addr  = r_addr_hold;
    case (r_state)
      S_IDLE: begin
        req_ready = r_live;
        if (w_accept) w_next = req_write ? S_WRITE : S_READ;
      end
      S_READ: begin
        mem_oe   = 1'b1;
        mem_addr = w_rd_addr;
        w_next   = S_RSP;
      end
      S_WRITE: begin
        mem_addr = r_addr;
        mem_din  = r_wdata;
        mem_wea  = r_be;
        w_next   = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = r_rsp_last ? S_IDLE : S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live      <= 1'b0;
      r_quad      <= 1'b0;
      r_addr      <= '0;
      r_addr_hold <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_beat      <= '0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_quad  <= req_quad & ~req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_beat  <= '0;
          end
        end
        S_READ: begin
          r_rsp_data  <= mem_dout;
          r_rsp_last  <= !r_quad || (r_beat == 2'd3);
          r_addr_hold <= w_rd_addr;
        end
        S_WRITE: begin
          r_rsp_data  <= '0;
          r_rsp_last  <= 1'b1;
          r_addr_hold <= r_addr;
        end
        S_RSP: begin
          if (rsp_ready && !r_rsp_last) r_beat <= r_beat + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_mem_seq.sv
// Directed bench for sim_mem_seq with a byte-lane memory model (lane 0 = MSB lane).
module tb_sim_mem_seq;
  localparam int SIZE = 4096, WIDTH = 36, NBYTES = 4, AW = 12, LW = WIDTH / NBYTES;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_quad = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic [NBYTES-1:0] req_be = '0;
  logic req_ready, rsp_valid, rsp_last, mem_oe;
  logic [WIDTH-1:0] rsp_data, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [NBYTES-1:0] mem_wea;

  always #5 clk = ~clk;

  sim_mem_seq #(.SIZE(SIZE), .WIDTH(WIDTH), .NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_quad(req_quad), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea),
    .mem_oe(mem_oe), .mem_dout(mem_dout));

  logic [WIDTH-1:0] mem [SIZE];
  int n_wr = 0;
  always @(posedge clk) begin
    if (mem_wea != '0) n_wr++;
    for (int i = 0; i < NBYTES; i++)
      if (mem_wea[i]) mem[mem_addr][WIDTH-1-i*LW -: LW] <= mem_din[WIDTH-1-i*LW -: LW];
  end
  assign mem_dout = mem_oe ? mem[mem_addr] : '0;

  typedef struct {
    logic wr; logic quad; logic [AW-1:0] addr; logic [WIDTH-1:0] wdata;
    logic [NBYTES-1:0] be; int nb; logic [3:0][WIDTH-1:0] d;
  } vec_t;

  vec_t vt[14];
  int n_cmp = 0, n_bad = 0;

  function automatic vec_t mk(logic wr, logic q, logic [AW-1:0] a, logic [WIDTH-1:0] wd,
                              logic [NBYTES-1:0] b, int nb, logic [WIDTH-1:0] e0,
                              logic [WIDTH-1:0] e1, logic [WIDTH-1:0] e2, logic [WIDTH-1:0] e3);
    vec_t v;
    v.wr = wr; v.quad = q; v.addr = a; v.wdata = wd; v.be = b; v.nb = nb;
    v.d = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic wr, input logic q, input logic [AW-1:0] a,
                      input logic [WIDTH-1:0] wd, input logic [NBYTES-1:0] b);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_quad = q; req_addr = a; req_wdata = wd; req_be = b;
    t = 0;
    while (!req_ready && t < 40) begin @(negedge clk); t++; end
    check("accept_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Starts just after the accept edge; each beat must appear exactly two negedges later.
  task automatic collect(input logic [AW-1:0] a, input int nb, input logic [3:0][WIDTH-1:0] d,
                         input bit stall);
    int t;
    logic [1:0] lo;
    logic [WIDTH-1:0] held;
    for (int b = 0; b < nb; b++) begin
      t = 0;
      while (!rsp_valid && t < 40) begin
        @(negedge clk); t++;
        if (mem_oe) begin
          lo = a[1:0] + b[1:0];
          check("rd_addr", {52'd0, mem_addr}, {52'd0, a[AW-1:2], lo});
        end
      end
      check("beat_latency", t, 2);
      check("rsp_data", {28'd0, rsp_data}, {28'd0, d[b]});
      check("rsp_last", {63'd0, rsp_last}, {63'd0, (b == nb - 1)});
      if (stall) begin
        held = rsp_data;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          check("stall_valid", {63'd0, rsp_valid}, 64'd1);
          check("stall_data", {28'd0, rsp_data}, {28'd0, held});
          check("stall_oe", {63'd0, mem_oe}, 64'd0);
          check("stall_ready", {63'd0, req_ready}, 64'd0);
        end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    @(negedge clk);
    check("no_extra_beat", {63'd0, rsp_valid}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input bit stall);
    int w0;
    logic [1:0] lo;
    w0 = n_wr;
    send(v.wr, v.quad, v.addr, v.wdata, v.be);
    collect(v.addr, v.nb, v.d, stall);
    lo = v.addr[1:0] + 2'(v.nb - 1);
    check("addr_hold", {52'd0, mem_addr}, v.wr ? {52'd0, v.addr} : {52'd0, v.addr[AW-1:2], lo});
    if (v.wr) check("write_cycles", n_wr - w0, (v.be != '0) ? 1 : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd0);
    check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check({tag, "_rsp_data"}, {28'd0, rsp_data}, 64'd0);
    check({tag, "_rsp_last"}, {63'd0, rsp_last}, 64'd0);
    check({tag, "_mem_addr"}, {52'd0, mem_addr}, 64'd0);
    check({tag, "_mem_din"}, {28'd0, mem_din}, 64'd0);
    check({tag, "_mem_wea"}, {60'd0, mem_wea}, 64'd0);
    check({tag, "_mem_oe"}, {63'd0, mem_oe}, 64'd0);
  endtask

  initial begin
    int w0;
    vt[0]  = mk(1, 0, 12'h010, 36'h123456789, 4'b1111, 1, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 12'h010, 0, 0, 1, 36'h123456789, 0, 0, 0);
    vt[2]  = mk(1, 0, 12'h010, 36'hFFFFFFFFF, 4'b0100, 1, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 12'h010, 0, 0, 1, 36'h12347FF89, 0, 0, 0);
    vt[4]  = mk(1, 0, 12'h020, 36'h1, 4'b1111, 1, 0, 0, 0, 0);
    vt[5]  = mk(1, 0, 12'h021, 36'h2, 4'b1111, 1, 0, 0, 0, 0);
    vt[6]  = mk(1, 0, 12'h022, 36'h3, 4'b1111, 1, 0, 0, 0, 0);
    vt[7]  = mk(1, 0, 12'h023, 36'h4, 4'b1111, 1, 0, 0, 0, 0);
    vt[8]  = mk(0, 1, 12'h022, 0, 0, 4, 36'h3, 36'h4, 36'h1, 36'h2);
    vt[9]  = mk(1, 0, 12'h020, 36'hFFFFFFFFF, 4'b0000, 1, 0, 0, 0, 0);
    vt[10] = mk(0, 0, 12'h020, 0, 0, 1, 36'h1, 0, 0, 0);
    vt[11] = mk(0, 1, 12'h020, 0, 0, 4, 36'h1, 36'h2, 36'h3, 36'h4);
    vt[12] = mk(0, 1, 12'h023, 0, 0, 4, 36'h4, 36'h1, 36'h2, 36'h3);
    vt[13] = mk(1, 0, 12'h040, 36'h111, 4'b1111, 1, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1; #1;
    check("ready_before_edge", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < 14; i++) run_vec(vt[i], 1'b0);

    // Quad read with a 10-cycle consumer stall on every beat.
    run_vec(mk(0, 1, 12'h022, 0, 0, 4, 36'h3, 36'h4, 36'h1, 36'h2), 1'b1);

    // Quad flag on a write is ignored: one write, one ack.
    run_vec(mk(1, 1, 12'h030, 36'h5, 4'b1111, 1, 0, 0, 0, 0), 1'b0);
    run_vec(mk(0, 0, 12'h030, 0, 0, 1, 36'h5, 0, 0, 0), 1'b0);

    // Reset during the RSP of beat 1 of a quad.
    send(0, 1, 12'h020, 0, 0);
    @(negedge clk); @(negedge clk);
    check("q_beat0", {28'd0, rsp_data}, 64'h1);
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("q_beat1_valid", {63'd0, rsp_valid}, 64'd1);
    check("q_beat1", {28'd0, rsp_data}, 64'h2);
    rst_n = 1'b0; #1;
    check_reset_outputs("mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end

    // Write aborted by reset before its commit edge leaves memory untouched.
    w0 = n_wr;
    send(1, 0, 12'h040, 36'h222, 4'b1111);
    check("abort_wea_live", {60'd0, mem_wea}, 64'hF);
    rst_n = 1'b0; #1;
    check("abort_wea_clear", {60'd0, mem_wea}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_write", n_wr - w0, 0);
    run_vec(mk(0, 0, 12'h040, 0, 0, 1, 36'h111, 0, 0, 0), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
